// File: rtl/uart_sample_scheduler_if.sv
// Byte handshake between uart_sample_scheduler (master) and uart_tx (slave).
interface uart_sample_scheduler_if;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       tx_busy;

   modport master (output tx_start, output tx_data, input tx_busy);
   modport slave  (input tx_start, input tx_data, output tx_busy);
endinterface

// File: rtl/uart_sample_scheduler.sv
// Captures NCH samples every DECIM-th sample_clk rise and streams 'C','H','0'+ch,MSB,LSB records to uart_tx.
// Optional: UART_FRAME_CHECKSUM_EN appends an XOR checksum byte to every record.
module uart_sample_scheduler #(
   parameter int unsigned W     = 16,
   parameter int unsigned NCH   = 4,
   parameter int unsigned DECIM = 32
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           sample_clk,
   input  logic                           enable,
   input  logic [W-1:0]                   sample_in0,
   input  logic [W-1:0]                   sample_in1,
   input  logic [W-1:0]                   sample_in2,
   input  logic [W-1:0]                   sample_in3,
   uart_sample_scheduler_if.master        tx,
   output logic                           frame_active,
   output logic [7:0]                     overrun_count,
   output logic                           frame_toggle
);

   generate
      if (W != 16) begin : g_bad_w
         $error("uart_sample_scheduler: W must be 16");
      end
      if (NCH < 1 || NCH > 4) begin : g_bad_nch
         $error("uart_sample_scheduler: NCH must be 1..4");
      end
      if (DECIM < 1 || DECIM > 255) begin : g_bad_decim
         $error("uart_sample_scheduler: DECIM must be 1..255");
      end
   endgenerate

`ifdef UART_FRAME_CHECKSUM_EN
   localparam logic [2:0] LAST_BYTE = 3'd5;
`else
   localparam logic [2:0] LAST_BYTE = 3'd4;
`endif
   localparam logic [7:0] DECIM_LAST = 8'(DECIM - 1);
   localparam logic [1:0] CH_LAST    = 2'(NCH - 1);

   typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_BUSY, WAIT_IDLE} state_t;

   state_t       state;
   logic         sample_clk_q;
   logic [7:0]   decim_cnt;
   logic [W-1:0] snap [4];
   logic [W-1:0] samples [4];
   logic [1:0]   ch;
   logic [2:0]   byte_idx;
   logic [1:0]   to_cnt;
   logic         rise;
   logic         capture;
   logic [7:0]   hdr_ch;
   logic [W-1:0] cur;
   logic [7:0]   csum;
   logic [7:0]   next_byte;

   assign samples[0] = sample_in0;
   assign samples[1] = sample_in1;
   assign samples[2] = sample_in2;
   assign samples[3] = sample_in3;

   assign rise    = sample_clk & ~sample_clk_q;
   assign capture = enable & rise & (decim_cnt == DECIM_LAST);

   always_comb begin
      hdr_ch    = 8'h30 + {6'd0, ch};
      cur       = snap[ch];
      csum      = 8'h43 ^ 8'h48 ^ hdr_ch ^ cur[15:8] ^ cur[7:0];
      next_byte = '0;
      case (byte_idx)
         3'd0:    next_byte = 8'h43;
         3'd1:    next_byte = 8'h48;
         3'd2:    next_byte = hdr_ch;
         3'd3:    next_byte = cur[15:8];
         3'd4:    next_byte = cur[7:0];
         default: next_byte = csum;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         sample_clk_q  <= 1'b0;
         decim_cnt     <= '0;
         ch            <= '0;
         byte_idx      <= '0;
         to_cnt        <= '0;
         tx.tx_start   <= 1'b0;
         tx.tx_data    <= '0;
         frame_active  <= 1'b0;
         overrun_count <= '0;
         frame_toggle  <= 1'b0;
         for (int unsigned i = 0; i < 4; i++) snap[i] <= '0;
      end else begin
         sample_clk_q <= sample_clk;
         tx.tx_start  <= 1'b0;

         if (!enable)
            decim_cnt <= '0;
         else if (rise)
            decim_cnt <= (decim_cnt == DECIM_LAST) ? '0 : decim_cnt + 8'd1;

         // A capture point while any frame is still in flight (including its final cycle) is dropped.
         if (capture && state != IDLE && overrun_count != 8'hFF)
            overrun_count <= overrun_count + 8'd1;

         case (state)
            IDLE: begin
               if (capture) begin
                  for (int unsigned i = 0; i < NCH; i++) snap[i] <= samples[i];
                  ch           <= '0;
                  byte_idx     <= '0;
                  frame_active <= 1'b1;
                  state        <= LOAD;
               end
            end
            LOAD: begin
               tx.tx_data <= next_byte;
               state      <= START;
            end
            START: begin
               if (!tx.tx_busy) begin
                  tx.tx_start <= 1'b1;
                  to_cnt      <= '0;
                  state       <= WAIT_BUSY;
               end
            end
            WAIT_BUSY: begin
               if (tx.tx_busy || to_cnt == 2'd3)
                  state <= WAIT_IDLE;
               else
                  to_cnt <= to_cnt + 2'd1;
            end
            WAIT_IDLE: begin
               if (!tx.tx_busy) begin
                  if (byte_idx == LAST_BYTE) begin
                     byte_idx <= '0;
                     if (ch == CH_LAST) begin
                        frame_active <= 1'b0;
                        frame_toggle <= ~frame_toggle;
                        state        <= IDLE;
                     end else begin
                        ch    <= ch + 2'd1;
                        state <= LOAD;
                     end
                  end else begin
                     byte_idx <= byte_idx + 3'd1;
                     state    <= LOAD;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_sample_scheduler.sv
// Self-checking bench for uart_sample_scheduler: fixed vector table, hand corner sequences, random traffic vs reference model.
module tb_uart_sample_scheduler;

   localparam int NCH_TB   = 4;
   localparam int DECIM_TB = 3;
`ifdef UART_FRAME_CHECKSUM_EN
   localparam int BPR = 6;
`else
   localparam int BPR = 5;
`endif
   localparam int NB = NCH_TB * BPR;

   logic        clk;
   logic        rst_n;
   logic        sample_clk;
   logic        enable;
   logic [15:0] smp [4];
   logic        frame_active;
   logic [7:0]  overrun_count;
   logic        frame_toggle;

   uart_sample_scheduler_if tx_if();

   uart_sample_scheduler #(.W(16), .NCH(NCH_TB), .DECIM(DECIM_TB)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .sample_clk    (sample_clk),
      .enable        (enable),
      .sample_in0    (smp[0]),
      .sample_in1    (smp[1]),
      .sample_in2    (smp[2]),
      .sample_in3    (smp[3]),
      .tx            (tx_if),
      .frame_active  (frame_active),
      .overrun_count (overrun_count),
      .frame_toggle  (frame_toggle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endfunction

   // uart_tx stand-in: busy for busy_len cycles after each accepted start
   int busy_len = 10;
   int busy_cnt = 0;
   always @(posedge clk) begin
      if (tx_if.tx_start) busy_cnt <= busy_len;
      else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
   end
   assign tx_if.tx_busy = (busy_cnt != 0);

   // Reference model: counts enabled rises, captures every DECIM-th, expects whole records in order
   logic [7:0] exp_q [$];
   logic [7:0] rx_log [$];
   bit         inflight  = 0;
   int         rx_cnt    = 0;
   int         quiet     = 0;
   int         dcnt      = 0;
   int         starts    = 0;
   bit         sc_prev   = 0;
   bit         start_prev = 0;
   bit         tog_exp   = 0;
   logic [7:0] ov_exp    = 0;

   task automatic push_frame();
      logic [7:0] rec [6];
      logic [7:0] x;
      for (int c = 0; c < NCH_TB; c++) begin
         rec[0] = 8'h43; rec[1] = 8'h48; rec[2] = 8'h30 + 8'(c);
         rec[3] = smp[c][15:8]; rec[4] = smp[c][7:0];
         x = '0;
         for (int b = 0; b < 5; b++) x ^= rec[b];
         rec[5] = x;
         for (int b = 0; b < BPR; b++) exp_q.push_back(rec[b]);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (!rst_n) begin
         exp_q.delete();
         inflight = 0; rx_cnt = 0; quiet = 0; dcnt = 0;
         sc_prev = 0; start_prev = 0; tog_exp = 0; ov_exp = '0;
      end else begin
         if (tx_if.tx_start) begin
            starts++;
            rx_log.push_back(tx_if.tx_data);
            chk("start_one_cycle", 32'(start_prev), 32'd0);
            if (exp_q.size() == 0) chk("unexpected_start", 32'd1, 32'd0);
            else begin
               chk("tx_byte", 32'(tx_if.tx_data), 32'(exp_q.pop_front()));
               rx_cnt++;
            end
         end
         start_prev = tx_if.tx_start;
         if (!enable) dcnt = 0;
         else if (sample_clk && !sc_prev) begin
            if (dcnt == DECIM_TB - 1) begin
               dcnt = 0;
               if (!inflight) begin
                  push_frame();
                  inflight = 1; rx_cnt = 0; quiet = 0;
               end else if (ov_exp != 8'hFF) ov_exp++;
            end else dcnt++;
         end
         sc_prev = sample_clk;
         if (inflight && rx_cnt == NB) begin
            quiet = tx_if.tx_busy ? 0 : quiet + 1;
            if (quiet >= 8) begin
               inflight = 0;
               tog_exp  = ~tog_exp;
               chk("frame_toggle", 32'(frame_toggle), 32'(tog_exp));
               chk("overrun_at_end", 32'(overrun_count), 32'(ov_exp));
            end
         end
         if (!inflight) chk("frame_active_idle", 32'(frame_active), 32'd0);
         else if (rx_cnt < NB) chk("frame_active_busy", 32'(frame_active), 32'd1);
      end
   end

   task automatic pulse();
      int g = 0;
      @(negedge clk);
      while (inflight && rx_cnt == NB && g < 3000) begin @(negedge clk); g++; end
      if (g >= 3000) chk("pulse_guard_timeout", 32'd1, 32'd0);
      sample_clk = 1'b1;
      @(negedge clk);
      sample_clk = 1'b0;
   endtask

   task automatic wait_idle(int budget);
      int g = 0;
      while (inflight && g < budget) begin @(negedge clk); g++; end
      if (inflight) chk("frame_complete_timeout", 32'd1, 32'd0);
      repeat (2) @(negedge clk);
   endtask

   typedef struct {
      logic [3:0][15:0] s;
      int               busy;
      logic             tog;
      logic [159:0]     exp;
   } vec_t;

   initial begin
      vec_t       tbl [3];
      int         n, s0, g;
      logic [7:0] e, x;

      tbl[0] = '{s: {16'h0001, 16'h7FFF, 16'h8000, 16'h1234}, busy: 10, tog: 1'b1,
                 exp: {"CH0", 16'h1234, "CH1", 16'h8000, "CH2", 16'h7FFF, "CH3", 16'h0001}};
      tbl[1] = '{s: {16'h5A5A, 16'hA5A5, 16'hFFFF, 16'h0000}, busy: 0, tog: 1'b0,
                 exp: {"CH0", 16'h0000, "CH1", 16'hFFFF, "CH2", 16'hA5A5, "CH3", 16'h5A5A}};
      tbl[2] = '{s: {16'hF0F0, 16'h0F0F, 16'hBEEF, 16'hDEAD}, busy: 3, tog: 1'b1,
                 exp: {"CH0", 16'hDEAD, "CH1", 16'hBEEF, "CH2", 16'h0F0F, "CH3", 16'hF0F0}};

      rst_n = 1'b0; sample_clk = 1'b0; enable = 1'b1;
      for (int i = 0; i < 4; i++) smp[i] = 16'h1111 * 16'(i + 1);
      repeat (3) @(negedge clk);
      chk("rst_tx_start", 32'(tx_if.tx_start), 32'd0);
      chk("rst_tx_data", 32'(tx_if.tx_data), 32'd0);
      chk("rst_frame_active", 32'(frame_active), 32'd0);
      chk("rst_overrun", 32'(overrun_count), 32'd0);
      chk("rst_toggle", 32'(frame_toggle), 32'd0);
      rst_n = 1'b1;

      // Vector table; entry 0 also measures capture-to-start latency
      for (int i = 0; i < 3; i++) begin
         rx_log.delete();
         busy_len = tbl[i].busy;
         for (int c = 0; c < 4; c++) smp[c] = tbl[i].s[c];
         repeat (DECIM_TB - 1) pulse();
         @(negedge clk);
         sample_clk = 1'b1;
         n = 0;
         while (n < 12) begin
            @(negedge clk); n++;
            sample_clk = 1'b0;
            if (tx_if.tx_start) break;
         end
         if (i == 0) begin
            chk("latency", 32'(n), 32'd3);
            chk("first_byte", 32'(tx_if.tx_data), 32'h43);
         end
         for (int c = 0; c < 4; c++) smp[c] = 16'($urandom);
         wait_idle(4000);
         chk("tbl_len", 32'(rx_log.size()), 32'(NB));
         chk("tbl_toggle", 32'(frame_toggle), 32'(tbl[i].tog));
         for (int k = 0; k < NB && k < rx_log.size(); k++) begin
            if (k % BPR < 5) e = tbl[i].exp[159 - 8 * ((k / BPR) * 5 + k % BPR) -: 8];
            else begin
               x = '0;
               for (int b = 0; b < 5; b++) x ^= tbl[i].exp[159 - 8 * ((k / BPR) * 5 + b) -: 8];
               e = x;
            end
            chk("tbl_byte", 32'(rx_log[k]), 32'(e));
         end
      end

      // Capture point in the very cycle the last byte completes counts as overrun
      busy_len = 5;
      repeat (DECIM_TB) pulse();
      repeat (DECIM_TB - 1) pulse();
      g = 0;
      while (!(rx_cnt == NB && tx_if.tx_busy) && g < 3000) begin @(negedge clk); g++; end
      while (tx_if.tx_busy && g < 3000) begin @(negedge clk); g++; end
      chk("coincident_reached", 32'(g < 3000), 32'd1);
      sample_clk = 1'b1;
      @(negedge clk);
      sample_clk = 1'b0;
      s0 = starts;
      repeat (12) @(negedge clk);
      chk("coincident_overrun", 32'(overrun_count), 32'(ov_exp));
      chk("coincident_no_restart", 32'(starts), 32'(s0));
      chk("coincident_idle", 32'(frame_active), 32'd0);
      wait_idle(500);

      // enable dropped mid-frame: frame finishes, nothing afterwards
      busy_len = 8;
      for (int c = 0; c < 4; c++) smp[c] = 16'($urandom);
      repeat (DECIM_TB) pulse();
      g = 0;
      while (rx_cnt < 3 && g < 1000) begin @(negedge clk); g++; end
      enable = 1'b0;
      repeat (10) pulse();
      wait_idle(4000);
      s0 = starts;
      repeat (10 * DECIM_TB) pulse();
      repeat (10) @(negedge clk);
      chk("disabled_no_start", 32'(starts), 32'(s0));
      chk("disabled_overrun", 32'(overrun_count), 32'(ov_exp));
      chk("disabled_idle", 32'(frame_active), 32'd0);
      enable = 1'b1;

      // Saturation: 300 dropped snapshots during one long frame
      busy_len = 120;
      repeat (DECIM_TB) pulse();
      repeat (300 * DECIM_TB) pulse();
      chk("overrun_saturated", 32'(overrun_count), 32'd255);
      wait_idle(8000);

      // Asynchronous reset in the middle of byte 7's start pulse
      busy_len = 10;
      repeat (DECIM_TB) pulse();
      g = 0;
      while (!(tx_if.tx_start && rx_cnt == 8) && g < 3000) begin @(negedge clk); g++; end
      chk("byte7_reached", 32'(g < 3000), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_tx_start", 32'(tx_if.tx_start), 32'd0);
      chk("midrst_tx_data", 32'(tx_if.tx_data), 32'd0);
      chk("midrst_frame_active", 32'(frame_active), 32'd0);
      chk("midrst_overrun", 32'(overrun_count), 32'd0);
      chk("midrst_toggle", 32'(frame_toggle), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      rx_log.delete();
      repeat (DECIM_TB) pulse();
      wait_idle(4000);
      chk("post_rst_len", 32'(rx_log.size()), 32'(NB));
      if (rx_log.size() >= 3) begin
         chk("post_rst_C", 32'(rx_log[0]), 32'h43);
         chk("post_rst_ch0", 32'(rx_log[2]), 32'h30);
      end

      // Random traffic against the reference model
      for (int it = 0; it < 30; it++) begin
         for (int c = 0; c < 4; c++) smp[c] = 16'($urandom);
         busy_len = $urandom_range(0, 12);
         enable   = ($urandom_range(0, 9) != 0);
         n = $urandom_range(1, 2 * DECIM_TB);
         repeat (n) begin
            repeat ($urandom_range(0, 15)) @(negedge clk);
            pulse();
         end
      end
      enable = 1'b1;
      wait_idle(4000);
      chk("final_overrun", 32'(overrun_count), 32'(ov_exp));
      chk("final_toggle", 32'(frame_toggle), 32'(tog_exp));
      chk("final_idle", 32'(frame_active), 32'd0);
      chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

endmodule
